// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcodes,
// ALU operation and datapath mux select values.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_IMM_EXEC = 4'd9,
        S_IMM_WB   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRC_B_RT    = 2'd0;
    localparam logic [1:0] SRC_B_FOUR  = 2'd1;
    localparam logic [1:0] SRC_B_SIMM  = 2'd2;
    localparam logic [1:0] SRC_B_SHIMM = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait counter: cleared when a waiting state is entered, counts stalled
// cycles, and flags when the stall budget has been used up.
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    logic [7:0] count_reg;
    logic [7:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = 8'd0;
        end else if (count) begin
            count_next = count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= 8'd0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = (count_reg == 8'(MEM_WAIT_MAX));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory-stall timeout and sticky error flags.
// Define MC_JUMP_EN to support the j instruction; otherwise it decodes as illegal.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_OP_W     = 2,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          instr_op,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          pc_source,
    output logic [3:0]          state,
    output logic                illegal_op,
    output logic                mem_timeout
);

    state_t     state_reg;
    state_t     state_next;
    logic [1:0] alu_op_code;
    logic       timer_clear;
    logic       timer_count;
    logic       timer_expired;
    logic       set_illegal;
    logic       set_timeout;
    logic       illegal_reg;
    logic       timeout_reg;

    mem_wait_timer #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .srst    (rst),
        .clear   (timer_clear),
        .count   (timer_count),
        .expired (timer_expired)
    );

    // Any state change restarts the budget; only waiting states ever count.
    assign timer_clear = (state_next != state_reg);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_RT;
        alu_op_code   = ALU_ADD;
        pc_source     = PC_SRC_ALU;
        timer_count   = 1'b0;
        set_illegal   = 1'b0;
        set_timeout   = 1'b0;
        state_next    = state_reg;

        case (state_reg)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (timer_expired) begin
                    set_timeout = 1'b1;
                    state_next  = S_TRAP;
                end else begin
                    timer_count = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = SRC_B_SHIMM;
                case (instr_op)
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_IMM_EXEC;
`ifdef MC_JUMP_EN
                    OP_J:         state_next = S_JUMP;
`endif
                    default: begin
                        set_illegal = 1'b1;
                        state_next  = S_TRAP;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_SIMM;
                state_next = (instr_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (timer_expired) begin
                    set_timeout = 1'b1;
                    state_next  = S_TRAP;
                end else begin
                    timer_count = 1'b1;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (timer_expired) begin
                    set_timeout = 1'b1;
                    state_next  = S_TRAP;
                end else begin
                    timer_count = 1'b1;
                end
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_op_code = ALU_FUNCT;
                state_next  = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op_code   = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
                state_next    = S_FETCH;
            end
            S_IMM_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_SIMM;
                state_next = S_IMM_WB;
            end
            S_IMM_WB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
`ifdef MC_JUMP_EN
                pc_write   = 1'b1;
                pc_source  = PC_SRC_JUMP;
                state_next = S_FETCH;
`else
                state_next = S_TRAP;
`endif
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (set_illegal) begin
                illegal_reg <= 1'b1;
            end
            if (set_timeout) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign alu_op      = ALU_OP_W'(alu_op_code);
    assign state       = state_reg;
    assign illegal_op  = illegal_reg;
    assign mem_timeout = timeout_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: opcode cycle-count table, directed
// stall/trap/reset sequences, and randomized instructions against an
// instruction-level reference model.
module tb_multicycle_control;

    localparam int MAXW = 4;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] instr_op;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal_op, mem_timeout;
    logic [16:0] act_ctrl;

    multicycle_control #(
        .ALU_OP_W     (3),
        .MEM_WAIT_MAX (MAXW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_op      (instr_op),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state),
        .illegal_op    (illegal_op),
        .mem_timeout   (mem_timeout)
    );

    always #5 clk = ~clk;

    assign act_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Control outputs each state must present, straight from the state table.
    function automatic logic [16:0] exp_ctrl(input int st, input logic rdy);
        logic pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa;
        logic [1:0] sb, ps;
        logic [2:0] aop;
        {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa} = '0;
        sb = 2'd0; ps = 2'd0; aop = 3'd0;
        case (st)
            0:  begin mr = 1; sb = 2'd1; pw = rdy; irw = rdy; end
            1:  sb = 2'd3;
            2:  begin sa = 1; sb = 2'd2; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin sa = 1; aop = 3'd2; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; aop = 3'd1; pwc = 1; ps = 2'd1; end
            9:  begin sa = 1; sb = 2'd2; end
            10: rw = 1;
            11: begin pw = 1; ps = 2'd2; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, sb, aop, ps};
    endfunction

    typedef struct {
        int   st;
        logic rdy;
        logic ill;
        logic tmo;
    } cyc_t;

    cyc_t q[$];
    logic ill_m;
    logic tmo_m;

    function automatic void push(input int st, input logic rdy);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.ill = ill_m; c.tmo = tmo_m;
        q.push_back(c);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    // A waiting state with n stalled cycles; more than MAXW stalls means timeout.
    function automatic bit add_wait(input int st, input int n);
        if (n > MAXW) begin
            for (int i = 0; i <= MAXW; i++) push(st, 1'b0);
            tmo_m = 1'b1;
            return 1'b1;
        end
        for (int i = 0; i < n; i++) push(st, 1'b0);
        push(st, 1'b1);
        return 1'b0;
    endfunction

    function automatic bit build(input logic [5:0] op, input int fw, input int mw);
        bit trapped;
        q.delete();
        trapped = add_wait(0, fw);
        if (!trapped) begin
            push(1, rnd_bit());
            case (op)
                T_R:    begin push(6, rnd_bit()); push(7, rnd_bit()); end
                T_LW:   begin
                    push(2, rnd_bit());
                    trapped = add_wait(3, mw);
                    if (!trapped) push(4, rnd_bit());
                end
                T_SW:   begin push(2, rnd_bit()); trapped = add_wait(5, mw); end
                T_BEQ:  push(8, rnd_bit());
                T_ADDI: begin push(9, rnd_bit()); push(10, rnd_bit()); end
`ifdef MC_JUMP_EN
                T_J:    push(11, rnd_bit());
`endif
                default: begin ill_m = 1'b1; trapped = 1'b1; end
            endcase
        end
        if (trapped) begin
            for (int i = 0; i < 3; i++) push(12, rnd_bit());
        end
        return trapped;
    endfunction

    task automatic run_q(input logic [5:0] op);
        instr_op = op;
        foreach (q[i]) begin
            mem_ready = q[i].rdy;
            #1;
            check("state", 32'(state), 32'(q[i].st));
            check("ctrl", 32'(act_ctrl), 32'(exp_ctrl(q[i].st, q[i].rdy)));
            check("flags", {30'd0, illegal_op, mem_timeout}, {30'd0, q[i].ill, q[i].tmo});
            @(posedge clk);
            #1;
        end
        $display("instr op=%b cycles=%0d state_after=%0d ill=%0b tmo=%0b",
                 op, q.size(), state, illegal_op, mem_timeout);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ill_m = 1'b0;
        tmo_m = 1'b0;
        check("reset_state", 32'(state), 32'd0);
        check("reset_flags", {30'd0, illegal_op, mem_timeout}, 32'd0);
        check("reset_ctrl", 32'(act_ctrl), 32'(exp_ctrl(0, 1'b0)));
    endtask

    task automatic exec(input logic [5:0] op, input int fw, input int mw);
        bit t;
        t = build(op, fw, mw);
        run_q(op);
        if (t) do_reset();
    endtask

    typedef struct {
        logic [5:0] op;
        int         cycles;
        logic       ill;
    } vec_t;

    vec_t tbl[8];

    initial begin
        rst = 1'b1;
        instr_op = T_R;
        mem_ready = 1'b0;
        ill_m = 1'b0;
        tmo_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Opcode -> cycles back to FETCH with memory always ready (2 = trapped).
        tbl[0] = '{T_R,    4, 1'b0};
        tbl[1] = '{T_LW,   5, 1'b0};
        tbl[2] = '{T_SW,   4, 1'b0};
        tbl[3] = '{T_BEQ,  3, 1'b0};
        tbl[4] = '{T_ADDI, 4, 1'b0};
`ifdef MC_JUMP_EN
        tbl[5] = '{T_J,    3, 1'b0};
`else
        tbl[5] = '{T_J,    2, 1'b1};
`endif
        tbl[6] = '{T_BAD,  2, 1'b1};
        tbl[7] = '{6'b000001, 2, 1'b1};
        for (int i = 0; i < 8; i++) begin
            int n;
            do_reset();
            instr_op = tbl[i].op;
            mem_ready = 1'b1;
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (state != 4'd0 && state != 4'd12 && n < 20);
            check("table_cycles", 32'(n), 32'(tbl[i].cycles));
            check("table_illegal", 32'(illegal_op), 32'(tbl[i].ill));
            $display("table op=%b cycles=%0d illegal=%0b", tbl[i].op, n, illegal_op);
        end
        do_reset();

        // Directed corner cases.
        exec(T_R, 0, 0);
        exec(T_LW, 0, 3);
        exec(T_BEQ, 0, 0);
        exec(T_BAD, 0, 0);
        exec(T_J, 0, 0);
        exec(T_R, MAXW + 1, 0);
        exec(T_R, MAXW, 0);
        exec(T_SW, 0, MAXW);
        exec(T_LW, 0, MAXW + 1);
        exec(T_SW, 2, MAXW + 1);

        // Reset in the middle of a stalled load, then a full-budget fetch.
        instr_op = T_LW;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rd_state", 32'(state), 32'd3);
        do_reset();
        exec(T_ADDI, MAXW, 0);

        for (int it = 0; it < 60; it++) begin
            logic [5:0] op;
            int fw, mw;
            case ($urandom_range(0, 7))
                0: op = T_R;
                1: op = T_LW;
                2: op = T_SW;
                3: op = T_BEQ;
                4: op = T_ADDI;
                5: op = T_J;
                6: op = T_BAD;
                default: begin
                    op = 6'($urandom);
                    if (op == T_R || op == T_LW || op == T_SW || op == T_BEQ ||
                        op == T_ADDI || op == T_J) op = T_BAD;
                end
            endcase
            fw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, MAXW) : MAXW + 1;
            mw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, MAXW) : MAXW + 1;
            exec(op, fw, mw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
